dmem_ctrl: RTL and testbench

Parametrised multi-cycle data memory for the MIPS datapath, replacing the single-cycle combinational-read memory for multi-cycle and pipelined CPU builds. Accepts one load/store request at a time over a req/ready handshake, models a configurable number of wait states, and performs true byte-lane writes with no read-modify-write. Loads return sign- or zero-extended byte/halfword data. Misaligned accesses are flagged instead of silently wrapping.

---
 rtl/dmem_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory with a req/ready handshake, configurable wait states,
// true byte-lane stores and sign/zero-extended sub-word loads with misalignment flagging.
module dmem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic              ready,
    output logic              valid,
    output logic [31:0]       rdata,
    output logic              err
);
    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_next;
    logic [31:0]         mem [DEPTH];
    logic [3:0]          cnt;
    logic                we_q, sign_ext_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          size_q;

    logic                op_we, op_sign_ext;
    logic [ADDR_W-1:0]   op_addr;
    logic [31:0]         op_wdata;
    logic [1:0]          op_size;
    logic [ADDR_W-3:0]   idx;
    logic                accept, misaligned, access;
    logic [3:0]          lane_en;
    logic [31:0]         lane_data;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b11:   is_misaligned = 1'b0;
            2'b10:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b11:   lane_enables = 4'b0001 << off;
            2'b10:   lane_enables = off[1] ? 4'b1100 : 4'b0011;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b11:   lane_replicate = {4{d[7:0]}};
            2'b10:   lane_replicate = {2{d[15:0]}};
            default: lane_replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b11:   load_extend = {{24{sx & b[7]}}, b};
            2'b10:   load_extend = {{16{sx & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // With no wait states the access happens on the accept edge, so use the live inputs there.
    always_comb begin
        op_we       = we_q;
        op_addr     = addr_q;
        op_wdata    = wdata_q;
        op_size     = size_q;
        op_sign_ext = sign_ext_q;
        if (state == IDLE) begin
            op_we       = we;
            op_addr     = addr;
            op_wdata    = wdata;
            op_size     = size;
            op_sign_ext = sign_ext;
        end
    end

    assign idx        = op_addr[ADDR_W-1:2];
    assign accept     = (state == IDLE) && req;
    assign misaligned = is_misaligned(size, addr[1:0]);
    assign access     = (accept && !misaligned && NO_WAIT) || ((state == BUSY) && (cnt == 4'd0));
    assign lane_en    = lane_enables(op_size, op_addr[1:0]);
    assign lane_data  = lane_replicate(op_size, op_wdata);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = (misaligned || NO_WAIT) ? RESP : BUSY;
            BUSY:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst)                        cnt <= 4'd0;
        else if (accept && !misaligned) cnt <= CNT_INIT;
        else if ((state == BUSY) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q       <= we;
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size;
            sign_ext_q <= sign_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && access && op_we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) mem[idx][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (accept && misaligned) begin
            rdata <= 32'd0;
            err   <= 1'b1;
        end else if (access) begin
            rdata <= op_we ? 32'd0 : load_extend(mem[idx], op_addr[1:0], op_size, op_sign_ext);
            err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed and random requests checked against a byte-array memory model,
// plus handshake, reset-abort and zero-wait throughput checks.
module tb_dmem_ctrl;
    localparam int AW = 9;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we, sign_ext;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [1:0]    size;
    logic          ready, valid, err;
    logic [31:0]   rdata;

    logic          req0, we0, sx0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic [1:0]    size0;
    logic          ready0, valid0, err0;
    logic [31:0]   rdata0;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [7:0]    mb [512];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .size(size), .sign_ext(sign_ext), .ready(ready), .valid(valid),
        .rdata(rdata), .err(err)
    );

    dmem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .size(size0), .sign_ext(sx0), .ready(ready0), .valid(valid0),
        .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Little-endian byte memory: the byte at address a sits in lane a%4 of its word.
    task automatic model_access(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                                input logic [1:0] sz, input logic sx,
                                output logic [31:0] rd, output logic er);
        int n;
        longint unsigned v;
        n = (sz == 2'b11) ? 1 : (sz == 2'b10) ? 2 : 4;
        if ((n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0)) begin
            rd = 32'd0;
            er = 1'b1;
            return;
        end
        er = 1'b0;
        if (w) begin
            for (int i = 0; i < n; i++) mb[int'(a) + i] = 8'(d >> (8 * i));
            rd = 32'd0;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mb[int'(a) + i]) << (8 * i));
            if (sx && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                v = v | (64'hFFFF_FFFF & ~((64'd1 << (8 * n)) - 1));
            rd = v[31:0];
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic sx,
                        output logic [31:0] rd, output logic er, output int lat);
        int k;
        k = 0;
        while (!ready && k < 40) begin @(posedge clk); #1; k++; end
        req = 1'b1; we = w; addr = a; wdata = d; size = sz; sign_ext = sx;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
        size = 2'($urandom); sign_ext = 1'($urandom);
        lat = 1;
        while (!valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!valid) lat = -1;
        rd = rdata;
        er = err;
        @(posedge clk); #1;
        chk("ready_after_resp", ready, 1);
        chk("valid_one_cycle", valid, 0);
        chk("rdata_held", rdata, rd);
    endtask

    task automatic run(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sx, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_er, er;
        int          lat;
        model_access(w, a, d, sz, sx, exp_rd, exp_er);
        xact(w, a, d, sz, sx, rd, er, lat);
        chk("latency", lat, exp_er ? 1 : W + 1);
        chk("err", er, exp_er);
        chk("rdata", rd, exp_rd);
    endtask

    initial begin
        logic [31:0] rd, v;
        int          nv;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0; sign_ext = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; size0 = '0; sx0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 128; i++) run(1'b1, AW'(i * 4), $urandom, 2'b00, 1'b0, rd);

        run(1'b1, 9'h010, 32'hDEADBEEF, 2'b00, 1'b0, rd);
        run(1'b0, 9'h010, 32'h0, 2'b00, 1'b0, rd);
        chk("word_load", rd, 32'hDEADBEEF);

        // Lane 3 takes 0xAA, lanes 1:0 take 0x1234, lane 2 keeps 0xAD.
        run(1'b1, 9'h013, 32'h000000AA, 2'b11, 1'b0, rd);
        run(1'b1, 9'h010, 32'h00001234, 2'b10, 1'b0, rd);
        run(1'b0, 9'h010, 32'h0, 2'b00, 1'b0, rd);
        chk("lane_merge", rd, 32'hAAAD1234);

        run(1'b1, 9'h020, 32'h80FF7F01, 2'b00, 1'b0, rd);
        run(1'b0, 9'h021, 32'h0, 2'b11, 1'b1, rd);
        chk("lb_21_sx", rd, 32'h0000007F);
        run(1'b0, 9'h022, 32'h0, 2'b11, 1'b1, rd);
        chk("lb_22_sx", rd, 32'hFFFFFFFF);
        run(1'b0, 9'h022, 32'h0, 2'b10, 1'b0, rd);
        chk("lh_22_zx", rd, 32'h000080FF);
        run(1'b0, 9'h022, 32'h0, 2'b10, 1'b1, rd);
        chk("lh_22_sx", rd, 32'hFFFF80FF);

        run(1'b1, 9'h011, 32'h00005A5A, 2'b10, 1'b0, rd);
        run(1'b0, 9'h012, 32'h0, 2'b00, 1'b0, rd);
        run(1'b0, 9'h010, 32'h0, 2'b00, 1'b0, rd);
        chk("misaligned_no_write", rd, 32'hAAAD1234);

        // req held high throughout: exactly one response, no re-accept while busy.
        req = 1'b1; we = 1'b0; addr = 9'h020; size = 2'b00; sign_ext = 1'b0;
        @(posedge clk); #1;
        chk("hs_ready_low", ready, 0);
        nv = 0;
        for (int k = 0; k < W + 1; k++) begin
            nv += int'(valid);
            @(posedge clk); #1;
        end
        chk("hs_one_valid", nv, 1);
        chk("hs_ready_back", ready, 1);
        chk("hs_rdata", rdata, 32'h80FF7F01);
        req = 1'b0;
        @(posedge clk); #1;
        chk("hs_no_reaccept", ready, 1);

        // Reset while waiting: store dropped.
        req = 1'b1; we = 1'b1; addr = 9'h030; wdata = 32'h55; size = 2'b00;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("busy_rst_ready", ready, 1);
        chk("busy_rst_valid", valid, 0);
        nv = 0;
        repeat (W + 2) begin @(posedge clk); #1; nv += int'(valid); end
        chk("busy_rst_no_valid", nv, 0);
        run(1'b0, 9'h030, 32'h0, 2'b00, 1'b0, rd);

        // Reset on the access edge itself.
        req = 1'b1; we = 1'b1; addr = 9'h034; wdata = 32'hAAAA5555; size = 2'b00;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("acc_rst_valid", valid, 0);
        chk("acc_rst_ready", ready, 1);
        run(1'b0, 9'h034, 32'h0, 2'b00, 1'b0, rd);

        // req together with rst is not accepted.
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 9'h038; wdata = 32'h12345678; size = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        chk("rst_req_ready", ready, 1);
        @(posedge clk); #1;
        chk("rst_req_valid", valid, 0);
        run(1'b0, 9'h038, 32'h0, 2'b00, 1'b0, rd);

        for (int i = 0; i < 150; i++)
            run(1'($urandom), AW'($urandom), $urandom, 2'($urandom), 1'($urandom), rd);

        // Zero-wait instance: store, then back-to-back loads with req held high.
        v = $urandom;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h040; wdata0 = v; size0 = 2'b00; sx0 = 1'b0;
        @(posedge clk); #1;
        chk("w0_store_valid", valid0, 1);
        chk("w0_store_rdata", rdata0, 0);
        we0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("w0_valid_pattern", valid0, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) chk("w0_load_rdata", rdata0, v);
        end
        req0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
